// File: rtl/tetron_placer.sv
// Tetron placer: checks the four blocks of a piece against a 20x10 board
// through a one-cycle-latency read port, optionally locking the piece in by
// writing all four cells. One block is read and evaluated per two cycles; the
// first colliding or out-of-bounds block ends the operation.
//
// Handshake: start is sampled only in IDLE; the accepting edge latches op,
// anchor and offsets. busy stays high until the cycle after the single-cycle
// done pulse, and collision/oob hold their result until the next accepted
// start. All outputs are registered.
module tetron_placer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       op,
  input  logic [4:0] anchor_v,
  input  logic [4:0] anchor_h,
  input  logic [4:0] blk1_voffset,
  input  logic [4:0] blk1_hoffset,
  input  logic [4:0] blk2_voffset,
  input  logic [4:0] blk2_hoffset,
  input  logic [4:0] blk3_voffset,
  input  logic [4:0] blk3_hoffset,
  input  logic [4:0] blk4_voffset,
  input  logic [4:0] blk4_hoffset,
  output logic [7:0] board_rd_addr,
  input  logic       board_rd_data,
  output logic       board_wr_en,
  output logic [7:0] board_wr_addr,
  output logic       board_wr_data,
  output logic       busy,
  output logic       done,
  output logic       collision,
  output logic       oob,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_READ0  = 4'd1,
    S_READ1  = 4'd2,
    S_READ2  = 4'd3,
    S_READ3  = 4'd4,
    S_EVAL0  = 4'd5,
    S_EVAL1  = 4'd6,
    S_EVAL2  = 4'd7,
    S_EVAL3  = 4'd8,
    S_WRITE0 = 4'd9,
    S_WRITE1 = 4'd10,
    S_WRITE2 = 4'd11,
    S_WRITE3 = 4'd12,
    S_DONE   = 4'd13
  } state_t;

  // Returns {out_of_bounds, cell_address}; the address is forced to 0 when
  // the block falls off the board so it can drive the read port directly.
  function automatic logic [8:0] blk_pos(input logic [4:0] av, input logic [4:0] ah,
                                         input logic [4:0] vo, input logic [4:0] ho);
    logic [5:0] row;
    logic [5:0] col;
    logic [7:0] addr;
    row  = {1'b0, av} + {1'b0, vo};
    col  = {1'b0, ah} + {1'b0, ho};
    addr = ({2'b00, row} * 8'd10) + {2'b00, col};
    if ((row >= 6'd20) || (col >= 6'd10)) begin
      return {1'b1, 8'd0};
    end
    return {1'b0, addr};
  endfunction

  state_t          state_q, state_d;
  logic            op_q, op_d;
  logic [4:0]      anchor_v_q, anchor_v_d;
  logic [4:0]      anchor_h_q, anchor_h_d;
  logic [3:0][4:0] voff_q, voff_d;
  logic [3:0][4:0] hoff_q, hoff_d;
  logic [7:0]      rd_addr_q, rd_addr_d;
  logic            wr_en_q, wr_en_d;
  logic [7:0]      wr_addr_q, wr_addr_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            collision_q, collision_d;
  logic            oob_q, oob_d;

  logic [3:0]      blk_oob;
  logic [3:0][7:0] blk_addr;
  logic [8:0]      in_pos0;
  logic [1:0]      idx;
  logic [1:0]      idx_nxt;

  // Positions of the four latched blocks plus block 0 straight from the
  // inputs, needed on the accepting edge before anything is latched.
  always_comb begin
    logic [8:0] p;
    blk_oob  = '0;
    blk_addr = '0;
    for (int i = 0; i < 4; i++) begin
      p           = blk_pos(anchor_v_q, anchor_h_q, voff_q[i], hoff_q[i]);
      blk_oob[i]  = p[8];
      blk_addr[i] = p[7:0];
    end
    in_pos0 = blk_pos(anchor_v, anchor_h, blk1_voffset, blk1_hoffset);
  end

  // Block index implied by the current READ/EVAL/WRITE state.
  always_comb begin
    idx = 2'd0;
    case (state_q)
      S_READ1, S_EVAL1, S_WRITE1: idx = 2'd1;
      S_READ2, S_EVAL2, S_WRITE2: idx = 2'd2;
      S_READ3, S_EVAL3, S_WRITE3: idx = 2'd3;
      default:                    idx = 2'd0;
    endcase
    idx_nxt = idx + 2'd1;
  end

  // Next-state and next-output computation for the placer sequence.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    anchor_v_d  = anchor_v_q;
    anchor_h_d  = anchor_h_q;
    voff_d      = voff_q;
    hoff_d      = hoff_q;
    collision_d = collision_q;
    oob_d       = oob_q;
    rd_addr_d   = 8'd0;
    wr_en_d     = 1'b0;
    wr_addr_d   = 8'd0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d        = op;
          anchor_v_d  = anchor_v;
          anchor_h_d  = anchor_h;
          voff_d      = {blk4_voffset, blk3_voffset, blk2_voffset, blk1_voffset};
          hoff_d      = {blk4_hoffset, blk3_hoffset, blk2_hoffset, blk1_hoffset};
          collision_d = 1'b0;
          oob_d       = 1'b0;
          rd_addr_d   = in_pos0[7:0];
          state_d     = S_READ0;
        end
      end

      S_READ0, S_READ1, S_READ2, S_READ3: begin
        // Read data for this block arrives during the following EVAL cycle.
        state_d = state_t'(state_q + 4'd4);
      end

      S_EVAL0, S_EVAL1, S_EVAL2, S_EVAL3: begin
        if (blk_oob[idx] || board_rd_data) begin
          collision_d = 1'b1;
          oob_d       = blk_oob[idx];
          state_d     = S_DONE;
        end else if (idx != 2'd3) begin
          rd_addr_d = blk_addr[idx_nxt];
          state_d   = state_t'(state_q - 4'd3);
        end else if (op_q) begin
          wr_en_d   = 1'b1;
          wr_addr_d = blk_addr[0];
          state_d   = S_WRITE0;
        end else begin
          state_d = S_DONE;
        end
      end

      S_WRITE0, S_WRITE1, S_WRITE2, S_WRITE3: begin
        if (idx != 2'd3) begin
          wr_en_d   = 1'b1;
          wr_addr_d = blk_addr[idx_nxt];
          state_d   = state_t'(state_q + 4'd1);
        end else begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State, latched operands and registered outputs; reset aborts everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= 1'b0;
      anchor_v_q  <= '0;
      anchor_h_q  <= '0;
      voff_q      <= '0;
      hoff_q      <= '0;
      rd_addr_q   <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      collision_q <= 1'b0;
      oob_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      anchor_v_q  <= anchor_v_d;
      anchor_h_q  <= anchor_h_d;
      voff_q      <= voff_d;
      hoff_q      <= hoff_d;
      rd_addr_q   <= rd_addr_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      collision_q <= collision_d;
      oob_q       <= oob_d;
    end
  end

  assign board_rd_addr = rd_addr_q;
  assign board_wr_en   = wr_en_q;
  assign board_wr_addr = wr_addr_q;
  assign board_wr_data = 1'b1;
  assign busy          = busy_q;
  assign done          = done_q;
  assign collision     = collision_q;
  assign oob           = oob_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_tetron_placer.sv
// Directed bench for tetron_placer with a behavioural 200-cell board.
module tb_tetron_placer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       op = 1'b0;
  logic [4:0] anchor_v = '0, anchor_h = '0;
  logic [4:0] b1v = '0, b1h = '0, b2v = '0, b2h = '0, b3v = '0, b3h = '0, b4v = '0, b4h = '0;
  logic [7:0] board_rd_addr;
  logic       board_rd_data = 1'b0;
  logic       board_wr_en;
  logic [7:0] board_wr_addr;
  logic       board_wr_data;
  logic       busy, done, collision, oob;
  logic [3:0] state_dbg;

  int errors = 0;
  int checks = 0;

  logic       board [0:199];
  logic [7:0] wr_q  [$];
  logic [7:0] exp_q [$];

  logic [7:0] rd_log    [0:16];
  logic       wr_en_log [0:16];
  logic [7:0] wr_addr_log [0:16];
  logic       busy_log  [0:16];
  logic       coll_log  [0:16];
  logic       oob_log   [0:16];
  logic [3:0] state_log [0:16];
  int         done_cyc;
  int         done_cnt;

  tetron_placer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .anchor_v(anchor_v), .anchor_h(anchor_h),
    .blk1_voffset(b1v), .blk1_hoffset(b1h),
    .blk2_voffset(b2v), .blk2_hoffset(b2h),
    .blk3_voffset(b3v), .blk3_hoffset(b3h),
    .blk4_voffset(b4v), .blk4_hoffset(b4h),
    .board_rd_addr(board_rd_addr), .board_rd_data(board_rd_data),
    .board_wr_en(board_wr_en), .board_wr_addr(board_wr_addr),
    .board_wr_data(board_wr_data),
    .busy(busy), .done(done), .collision(collision), .oob(oob),
    .state_dbg(state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  // Board memory: registered read, write committed at the edge
  always @(posedge clk) begin
    board_rd_data <= (board_rd_addr < 8'd200) ? board[board_rd_addr] : 1'b0;
    if (board_wr_en && board_wr_addr < 8'd200) begin
      board[board_wr_addr] = board_wr_data;
      wr_q.push_back(board_wr_addr);
    end
  end

  task automatic clear_board();
    @(negedge clk);
    for (int i = 0; i < 200; i++) board[i] = 1'b0;
  endtask

  // Launch one operation with the square piece offsets and log 16 cycles.
  // Cycle c is the interval after edge c-1; edge 0 accepts start.
  task automatic run_op(input logic op_i, input logic [4:0] av, input logic [4:0] ah,
                        input int pulse_cyc, input int rst_cyc);
    @(negedge clk);
    op = op_i; anchor_v = av; anchor_h = ah;
    b1v = 5'd0; b1h = 5'd0; b2v = 5'd1; b2h = 5'd1;
    b3v = 5'd0; b3h = 5'd1; b4v = 5'd1; b4h = 5'd0;
    start = 1'b1;
    wr_q.delete();
    done_cyc = 0;
    done_cnt = 0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (c == 1) begin
        op       = ~op_i;
        anchor_v = 5'($urandom_range(0, 31));
        anchor_h = 5'($urandom_range(0, 31));
        b1v = 5'($urandom_range(2, 31)); b1h = 5'($urandom_range(2, 31));
        b2v = 5'($urandom_range(2, 31)); b2h = 5'($urandom_range(2, 31));
        b3v = 5'($urandom_range(2, 31)); b3h = 5'($urandom_range(2, 31));
        b4v = 5'($urandom_range(2, 31)); b4h = 5'($urandom_range(2, 31));
      end
      rd_log[c]      = board_rd_addr;
      wr_en_log[c]   = board_wr_en;
      wr_addr_log[c] = board_wr_addr;
      busy_log[c]    = busy;
      coll_log[c]    = collision;
      oob_log[c]     = oob;
      state_log[c]   = state_dbg;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = c;
      end
      start = (c == pulse_cyc);
      if (c == rst_cyc) rst_n = 1'b0;
      if (rst_cyc > 0 && c == rst_cyc + 2) rst_n = 1'b1;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    op    = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b expected 0", done); end
    checks++; if (collision !== 1'b0) begin errors++; $display("FAIL reset_collision: got %0b expected 0", collision); end
    checks++; if (oob !== 1'b0) begin errors++; $display("FAIL reset_oob: got %0b expected 0", oob); end
    checks++; if (board_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %0b expected 0", board_wr_en); end
    checks++; if (board_rd_addr !== 8'd0) begin errors++; $display("FAIL reset_rd_addr: got %0d expected 0", board_rd_addr); end
    checks++; if (board_wr_addr !== 8'd0) begin errors++; $display("FAIL reset_wr_addr: got %0d expected 0", board_wr_addr); end
    checks++; if (state_dbg !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state_dbg); end
    start = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got busy %0b expected 0", busy); end
  endtask

  task automatic test_check_clear();
    logic [7:0] exp_rd [4];
    exp_rd = '{8'd54, 8'd65, 8'd55, 8'd64};
    clear_board();
    run_op(1'b0, 5'd5, 5'd4, -1, -1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_log[2*i+1] !== exp_rd[i]) begin
        errors++; $display("FAIL clear_rd_addr%0d: got %0d expected %0d", i, rd_log[2*i+1], exp_rd[i]);
      end
    end
    checks++; if (done_cyc != 9) begin errors++; $display("FAIL clear_done_cycle: got %0d expected 9", done_cyc); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL clear_done_pulses: got %0d expected 1", done_cnt); end
    checks++; if (coll_log[16] !== 1'b0) begin errors++; $display("FAIL clear_collision: got %0b expected 0", coll_log[16]); end
    checks++; if (oob_log[16] !== 1'b0) begin errors++; $display("FAIL clear_oob: got %0b expected 0", oob_log[16]); end
    checks++; if (busy_log[1] !== 1'b1 || busy_log[9] !== 1'b1 || busy_log[10] !== 1'b0) begin
      errors++; $display("FAIL clear_busy: got c1=%0b c9=%0b c10=%0b expected 1 1 0", busy_log[1], busy_log[9], busy_log[10]);
    end
    checks++; if (wr_q.size() != 0) begin errors++; $display("FAIL clear_no_write: got %0d writes expected 0", wr_q.size()); end
  endtask

  task automatic test_collision();
    int reads55;
    clear_board();
    board[65] = 1'b1;
    run_op(1'b0, 5'd5, 5'd4, -1, -1);
    reads55 = 0;
    for (int c = 1; c <= 16; c++) if (rd_log[c] === 8'd55) reads55++;
    checks++; if (rd_log[3] !== 8'd65) begin errors++; $display("FAIL coll_rd_addr1: got %0d expected 65", rd_log[3]); end
    checks++; if (done_cyc != 5) begin errors++; $display("FAIL coll_done_cycle: got %0d expected 5", done_cyc); end
    checks++; if (coll_log[16] !== 1'b1) begin errors++; $display("FAIL coll_collision: got %0b expected 1", coll_log[16]); end
    checks++; if (oob_log[16] !== 1'b0) begin errors++; $display("FAIL coll_oob: got %0b expected 0", oob_log[16]); end
    checks++; if (reads55 != 0) begin errors++; $display("FAIL coll_no_read55: got %0d reads expected 0", reads55); end
  endtask

  task automatic test_oob_row();
    clear_board();
    run_op(1'b0, 5'd19, 5'd4, -1, -1);
    checks++; if (coll_log[1] !== 1'b0) begin errors++; $display("FAIL row_collision_cleared: got %0b expected 0", coll_log[1]); end
    checks++; if (rd_log[1] !== 8'd194) begin errors++; $display("FAIL row_rd_addr0: got %0d expected 194", rd_log[1]); end
    checks++; if (rd_log[3] !== 8'd0) begin errors++; $display("FAIL row_rd_addr1: got %0d expected 0", rd_log[3]); end
    checks++; if (done_cyc != 5) begin errors++; $display("FAIL row_done_cycle: got %0d expected 5", done_cyc); end
    checks++; if (coll_log[16] !== 1'b1) begin errors++; $display("FAIL row_collision: got %0b expected 1", coll_log[16]); end
    checks++; if (oob_log[16] !== 1'b1) begin errors++; $display("FAIL row_oob: got %0b expected 1", oob_log[16]); end
  endtask

  task automatic test_oob_col();
    clear_board();
    run_op(1'b0, 5'd0, 5'd9, -1, -1);
    checks++; if (rd_log[1] !== 8'd9) begin errors++; $display("FAIL col_rd_addr0: got %0d expected 9", rd_log[1]); end
    checks++; if (done_cyc != 5) begin errors++; $display("FAIL col_done_cycle: got %0d expected 5", done_cyc); end
    checks++; if (oob_log[16] !== 1'b1) begin errors++; $display("FAIL col_oob: got %0b expected 1", oob_log[16]); end
    checks++; if (coll_log[16] !== 1'b1) begin errors++; $display("FAIL col_collision: got %0b expected 1", coll_log[16]); end
  endtask

  task automatic test_lock();
    logic [7:0] exp_wr [4];
    exp_wr = '{8'd0, 8'd11, 8'd1, 8'd10};
    clear_board();
    run_op(1'b1, 5'd0, 5'd0, -1, -1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (wr_en_log[9+i] !== 1'b1 || wr_addr_log[9+i] !== exp_wr[i]) begin
        errors++; $display("FAIL lock_write%0d: got en=%0b addr=%0d expected en=1 addr=%0d",
                            i, wr_en_log[9+i], wr_addr_log[9+i], exp_wr[i]);
      end
    end
    checks++; if (wr_en_log[8] !== 1'b0 || wr_en_log[13] !== 1'b0) begin
      errors++; $display("FAIL lock_wr_en_edges: got c8=%0b c13=%0b expected 0 0", wr_en_log[8], wr_en_log[13]);
    end
    checks++; if (done_cyc != 13) begin errors++; $display("FAIL lock_done_cycle: got %0d expected 13", done_cyc); end
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(exp_wr[i]);
    checks++; if (wr_q != exp_q) begin errors++; $display("FAIL lock_board_writes: got %0d writes expected %0d", wr_q.size(), exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    // Piece locked at (0,0) by the previous test: block 0 now collides
    run_op(1'b0, 5'd0, 5'd0, -1, -1);
    checks++; if (done_cyc != 3) begin errors++; $display("FAIL b2b_done_cycle: got %0d expected 3", done_cyc); end
    checks++; if (coll_log[16] !== 1'b1 || oob_log[16] !== 1'b0) begin
      errors++; $display("FAIL b2b_flags: got coll=%0b oob=%0b expected 1 0", coll_log[16], oob_log[16]);
    end
  endtask

  task automatic test_reset_in_write();
    clear_board();
    run_op(1'b1, 5'd0, 5'd0, 4, 10);
    exp_q.delete();
    exp_q.push_back(8'd0);
    exp_q.push_back(8'd11);
    checks++; if (state_log[5] !== 4'd3) begin errors++; $display("FAIL ignore_start_state: got %0d expected 3", state_log[5]); end
    checks++; if (wr_en_log[10] !== 1'b1 || wr_addr_log[10] !== 8'd11) begin
      errors++; $display("FAIL rstw_write1: got en=%0b addr=%0d expected en=1 addr=11", wr_en_log[10], wr_addr_log[10]);
    end
    checks++; if (wr_en_log[11] !== 1'b0) begin errors++; $display("FAIL rstw_wr_en: got %0b expected 0", wr_en_log[11]); end
    checks++; if (busy_log[11] !== 1'b0) begin errors++; $display("FAIL rstw_busy: got %0b expected 0", busy_log[11]); end
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL rstw_no_done: got %0d pulses expected 0", done_cnt); end
    checks++; if (wr_q != exp_q) begin errors++; $display("FAIL rstw_writes: got %0d writes expected 2 (0,11)", wr_q.size()); end
    checks++; if (board[0] !== 1'b1 || board[11] !== 1'b1 || board[1] !== 1'b0) begin
      errors++; $display("FAIL rstw_cells: got c0=%0b c11=%0b c1=%0b expected 1 1 0", board[0], board[11], board[1]);
    end
  endtask

  initial begin
    for (int i = 0; i < 200; i++) board[i] = 1'b0;
    test_reset();
    test_check_clear();
    test_collision();
    test_oob_row();
    test_oob_col();
    test_lock();
    test_back_to_back();
    test_reset_in_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
